nibble_serial_sub: RTL and testbench

NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

---
 rtl/nibble_serial_sub_pkg.sv | 10 +
 rtl/nibble_serial_sub_if.sv | 28 ++
 rtl/nibble_sub_slice.sv | 17 +
 rtl/nibble_serial_sub.sv | 110 +++++++++++
 tb/tb_nibble_serial_sub.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM states and nibble width.
package nibble_serial_sub_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for nibble_serial_sub.
interface nibble_serial_sub_if
  import nibble_serial_sub_pkg::*;
#(
  parameter int NIB = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NIB_W*NIB-1:0] a;
  logic [NIB_W*NIB-1:0] b;
  logic                 bin;
  logic                 abort;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [NIB_W*NIB-1:0] diff;
  logic                 bout;

  modport master (
    output in_valid, a, b, bin, abort, out_ready,
    input  in_ready, busy, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, abort, out_ready,
    output in_ready, busy, out_valid, diff, bout
  );
endinterface

// File: rtl/nibble_sub_slice.sv
// One-nibble subtractor with borrow: d = x - y - bi (mod 16), bo = (x < y + bi).
module nibble_sub_slice
  import nibble_serial_sub_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             bi,
  output logic [NIB_W-1:0] d,
  output logic             bo
);
  logic [NIB_W:0] t;

  // The extra top bit goes high exactly when the difference is negative.
  assign t  = {1'b0, x} - {1'b0, y} - {{NIB_W{1'b0}}, bi};
  assign d  = t[NIB_W-1:0];
  assign bo = t[NIB_W];
endmodule

// File: rtl/nibble_serial_sub.sv
// Serial W-bit subtractor: one nibble per cycle, LSB first, with valid/ready handshakes.
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int NIB = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  nibble_serial_sub_if.slave bus
);
  localparam int W  = NIB_W * NIB;
  localparam int IW = $clog2(NIB + 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           brw_q, brw_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;

  logic [NIB_W-1:0] sl_x, sl_y, sl_d;
  logic             sl_bo;

  nibble_sub_slice u_slice (
    .x  (sl_x),
    .y  (sl_y),
    .bi (brw_q),
    .d  (sl_d),
    .bo (sl_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    sl_x = '0;
    sl_y = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx_q == IW'(n)) begin
        sl_x = a_q[n*NIB_W +: NIB_W];
        sl_y = b_q[n*NIB_W +: NIB_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_q == IW'(NIB)) begin
          // Commit cycle after the last nibble publishes the final borrow,
          // giving a result NIB+1 cycles after acceptance.
          bout_d  = brw_q;
          state_d = DONE;
        end else begin
          for (int unsigned n = 0; n < NIB; n++) begin
            if (idx_q == IW'(n)) diff_d[n*NIB_W +: NIB_W] = sl_d;
          end
          brw_d = sl_bo;
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Randomized scoreboard bench for nibble_serial_sub against an arithmetic reference model.
module tb_nibble_serial_sub;
  localparam int NIB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_sub_if #(.NIB(NIB)) bus ();

  nibble_serial_sub #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic bi);
    int unsigned av_i, sub_i;
    logic [15:0] d;
    av_i  = av;
    sub_i = bv + bi;
    d     = 16'((av_i + 32'h10000 * 2 - sub_i) % 32'h10000);
    return {(av_i < sub_i), d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.abort) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.out_valid), 32'(1'b0));
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("diff", 32'(bus.diff), 32'(e[15:0]));
        chk("bout", 32'(bus.bout), 32'(e[16]));
      end
    end
  end

  // mode: 0 normal (hold = backpressure cycles), 1 abort in RUN after `hold` cycles,
  // 2 abort in DONE with out_ready = hold[0], 3 abort held high during the IDLE accept
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       input int unsigned hold, input int unsigned mode);
    int unsigned n;
    logic [16:0] e;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    e = model(av, bv, bi);
    bus.a = av; bus.b = bv; bus.bin = bi; bus.in_valid = 1'b1;
    bus.out_ready = ((mode == 0) && (hold == 0)) || (mode == 3);
    bus.abort = (mode == 3);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.abort = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    if (mode == 1) begin
      repeat (hold) begin @(posedge clk); #1; end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_run_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_run_busy", 32'(bus.busy), 32'd0);
      e = exp_q.pop_back();
      repeat (NIB + 2) begin
        @(posedge clk); #1;
        chk("abort_run_no_valid", 32'(bus.out_valid), 32'd0);
      end
      return;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.out_valid && n < 20);
    chk("latency", n, NIB + 1);
    if (mode == 2) begin
      bus.abort = 1'b1; bus.out_ready = hold[0];
      @(posedge clk); #1;
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      chk("abort_done_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_done_out_valid", 32'(bus.out_valid), 32'd0);
      e = exp_q.pop_back();
      return;
    end
    if (hold > 0) begin
      for (int unsigned i = 0; i < hold; i++) begin
        chk("hold_diff", 32'(bus.diff), 32'(e[15:0]));
        chk("hold_bout", 32'(bus.bout), 32'(e[16]));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        if (i == 0) bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_after_done", 32'(bus.in_ready), 32'd1);
    chk("valid_drop_after_done", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic reset_mid_run(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    logic [16:0] e;
    bus.a = av; bus.b = bv; bus.bin = bi; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    exp_q.push_back(model(av, bv, bi));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    e = exp_q.pop_back();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_diff", 32'(bus.diff), 32'd0);
    chk("reset_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0034, 1'b0, 0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 0, 0);
    do_op(16'hEEEE, 16'hEEEE, 1'b1, 0, 0);
    do_op(16'hEEEE, 16'hEEEE, 1'b0, 0, 0);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 6, 0);
    reset_mid_run(16'($urandom), 16'($urandom), 1'($urandom));
    do_op(16'h5A5A, 16'hA5A5, 1'b1, 0, 0);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 2, 1);
    do_op(16'h8000, 16'h0001, 1'b0, 0, 0);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 1);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), NIB, 1);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 1, 2);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 2);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 3);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 0);
    do_op(16'h0000, 16'hFFFF, 1'b1, 0, 0);
    for (int unsigned k = 0; k < 40; k++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
